display_layer_arbiter: RTL and testbench
========================================

Name: display_layer_arbiter

Overview:
Per-pixel arbiter that shares the single RGB input of the screen display block among NUM_LAYERS drawing requesters (background, sprites, HUD).
- Selects the highest-priority enabled requester each pixel clock and drives Red_level/Green_level/Blue_level through one register stage.
- Layer-enable mask and background colour are configured through a valid/ready port. Configuration is double-buffered and commits only on the frame pulse, so a frame never tears.

Parameters:
NUM_LAYERS, 4, number of requesters; index 0 = highest priority
COLOR_W, 4, bits per colour channel
IDX_W, $clog2(NUM_LAYERS), width of the winner index

Ports:
clk_25  in  1  pixel clock
reset  in  1  asynchronous, active-high reset
frame  in  1  one-cycle pulse at start of frame, from the VGA timing controller
disp_ena  in  1  active-video indicator
draw_req  in  NUM_LAYERS  per-layer "pixel is mine" request
layer_rgb  in  NUM_LAYERS*3*COLOR_W  per-layer {R,G,B}; layer i occupies slice i
cfg_valid  in  1  configuration write request
cfg_ready  out  1  configuration write can be accepted
cfg_enable_mask  in  NUM_LAYERS  new layer-enable mask
cfg_bg_rgb  in  3*COLOR_W  new background {R,G,B}
Red_level  out  COLOR_W  selected red
Green_level  out  COLOR_W  selected green
Blue_level  out  COLOR_W  selected blue
winner_valid  out  1  some enabled layer won this pixel
winner_idx  out  IDX_W  index of the winning layer; 0 when winner_valid=0
pending_cfg  out  1  shadow config waiting for commit

Behaviour:
- Reset (async assert, sync release):
  - active mask = all ones; active bg = 0.
  - All colour outputs = 0; winner_valid = 0; winner_idx = 0.
  - Config FSM = IDLE; cfg_ready = 1; pending_cfg = 0.
- Arbitration (combinational):
  - eff = draw_req & active_mask.
  - Winner = lowest set index of eff.
  - If eff == 0, select active bg.
  - If disp_ena = 0, select 0 and force winner_valid = 0, regardless of requests.
- Latency: exactly 1 clk_25 cycle. Outputs registered from the cycle-N inputs are visible at cycle N+1. Requesters are responsible for aligning to this.
- Config FSM, states IDLE and PENDING:
  - IDLE: cfg_ready = 1. On cfg_valid, latch the mask and bg into shadow registers and go to PENDING.
  - PENDING: cfg_ready = 0, pending_cfg = 1. On frame, copy shadow to active and go to IDLE.
  - A frame pulse in IDLE leaves the active config unchanged.
- Simultaneous cfg_valid and frame while IDLE: the write is accepted into shadow, but does NOT commit on this frame; it commits on the next frame.
- Commit timing: the new active config is used from the cycle after the frame pulse. The pixel in the frame-pulse cycle still uses the old config.
- cfg_valid while PENDING: not accepted. The requester holds cfg_valid until it sees cfg_ready.
- Mask = all zeros is legal; the output is then background only.
- Reset mid-PENDING: the shadow is discarded and the active config returns to reset values.

Optional Feature:
COLLISION_DETECT_EN
- With the macro defined, additional outputs:
  - collision_mask [NUM_LAYERS]
  - collision_pulse [1]
- Accumulation: during disp_ena, bit i of an accumulator sets when layer i is in eff together with at least one other eff bit.
- On frame:
  - The accumulator is copied to collision_mask, and then cleared.
  - collision_pulse = 1 for one cycle if the copied value is nonzero.
- Precedence: a collision in the frame-pulse cycle itself is counted into the snapshot taken in that cycle.
- Reset clears both the accumulator and collision_mask, and collision_pulse = 0.
- Without the macro: the ports and logic are absent and the behaviour is otherwise identical.

Decomposition:
- Package display_pkg holds:
  - COLOR_W
  - typedef rgb_t as a struct {r, g, b}, each logic[COLOR_W-1:0]
  - cfg FSM enum {CFG_IDLE, CFG_PENDING}
  - BLACK_RGB constant
- Sub-module prio_encoder holds the parameterised lowest-index-first encoder producing {valid, idx}.

Test Plan:
1. Reset check: assert reset mid-frame → next cycle outputs are 0, cfg_ready = 1, mask = 4'b1111.
2. Priority selection: disp_ena = 1, draw_req = 4'b0110 (layer1 rgb = 12'hF00, layer2 = 12'h0F0) → one cycle later Red = F, Green = 0, winner_idx = 1, winner_valid = 1.
3. Masked commit, with draw_req = 4'b0110 held throughout:
   - Write mask 4'b1101 → cfg_ready drops; output is unchanged (still layer 1).
   - After the frame pulse, layer 2 wins (12'h0F0).
4. Background path and blanking:
   - draw_req = 0 and bg = 12'h00F committed → output 12'h00F, winner_valid = 0.
   - disp_ena = 0 with draw_req = 4'b1111 → output 0.
5. Simultaneous cfg_valid and frame in IDLE:
   - Config is not applied on that frame; pending_cfg = 1.
   - Config is applied after the next frame pulse.
6. COLLISION_DETECT_EN: layers 0 and 3 both request for one active pixel → at the next frame, collision_mask = 4'b1001 and a one-cycle collision_pulse; the following frame with no overlap gives collision_mask = 0.

Source files
------------

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared colour types, config FSM states and constants for the layer arbiter
package display_pkg;

  localparam int COLOR_W = 4;

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } rgb_t;

  typedef enum logic {
    CFG_IDLE,
    CFG_PENDING
  } cfg_state_t;

  localparam rgb_t BLACK_RGB = '0;

endpackage

// File: rtl/prio_encoder.sv
// rtl/prio_encoder.sv - lowest-index-first priority encoder producing {valid, idx}
module prio_encoder #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/display_layer_arbiter.sv
// rtl/display_layer_arbiter.sv - per-pixel layer arbiter with frame-committed config; COLLISION_DETECT_EN adds collision outputs
module display_layer_arbiter #(
  parameter int NUM_LAYERS = 4,
  parameter int COLOR_W    = display_pkg::COLOR_W,
  parameter int IDX_W      = $clog2(NUM_LAYERS)
) (
  input  logic                            clk_25,
  input  logic                            reset,
  input  logic                            frame,
  input  logic                            disp_ena,
  input  logic [NUM_LAYERS-1:0]           draw_req,
  input  logic [NUM_LAYERS*3*COLOR_W-1:0] layer_rgb,
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  input  logic [NUM_LAYERS-1:0]           cfg_enable_mask,
  input  logic [3*COLOR_W-1:0]            cfg_bg_rgb,
  output logic [COLOR_W-1:0]              Red_level,
  output logic [COLOR_W-1:0]              Green_level,
  output logic [COLOR_W-1:0]              Blue_level,
  output logic                            winner_valid,
  output logic [IDX_W-1:0]                winner_idx,
`ifdef COLLISION_DETECT_EN
  output logic [NUM_LAYERS-1:0]           collision_mask,
  output logic                            collision_pulse,
`endif
  output logic                            pending_cfg
);

  import display_pkg::*;

  localparam int RGB_W = 3 * COLOR_W;

  cfg_state_t              state_q;
  cfg_state_t              state_d;
  logic                    cfg_accept;
  logic                    cfg_commit;
  logic [NUM_LAYERS-1:0]   active_mask;
  logic [NUM_LAYERS-1:0]   shadow_mask;
  logic [RGB_W-1:0]        active_bg;
  logic [RGB_W-1:0]        shadow_bg;

  logic [NUM_LAYERS-1:0]   eff;
  logic                    enc_valid;
  logic [IDX_W-1:0]        enc_idx;
  logic [RGB_W-1:0]        sel_rgb;
  logic                    sel_valid;
  logic [IDX_W-1:0]        sel_idx;

  // Config handshake: accept into shadow while idle, commit shadow on the next frame pulse.
  always_comb begin
    state_d     = state_q;
    cfg_ready   = 1'b0;
    pending_cfg = 1'b0;
    cfg_accept  = 1'b0;
    cfg_commit  = 1'b0;
    case (state_q)
      CFG_IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          cfg_accept = 1'b1;
          state_d    = CFG_PENDING;
        end
      end
      CFG_PENDING: begin
        pending_cfg = 1'b1;
        if (frame) begin
          cfg_commit = 1'b1;
          state_d    = CFG_IDLE;
        end
      end
      default: state_d = CFG_IDLE;
    endcase
  end

  // Config state, shadow and active registers; reset discards any pending shadow.
  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) begin
      state_q     <= CFG_IDLE;
      active_mask <= '1;
      active_bg   <= RGB_W'(BLACK_RGB);
      shadow_mask <= '1;
      shadow_bg   <= RGB_W'(BLACK_RGB);
    end else begin
      state_q <= state_d;
      if (cfg_accept) begin
        shadow_mask <= cfg_enable_mask;
        shadow_bg   <= cfg_bg_rgb;
      end
      if (cfg_commit) begin
        active_mask <= shadow_mask;
        active_bg   <= shadow_bg;
      end
    end
  end

  assign eff = draw_req & active_mask;

  prio_encoder #(
    .N     (NUM_LAYERS),
    .IDX_W (IDX_W)
  ) u_prio_encoder (
    .req   (eff),
    .valid (enc_valid),
    .idx   (enc_idx)
  );

  // Pixel mux: blanking forces black, otherwise winner colour or background.
  always_comb begin
    sel_rgb   = '0;
    sel_valid = 1'b0;
    sel_idx   = '0;
    if (disp_ena) begin
      if (enc_valid) begin
        sel_rgb   = layer_rgb[int'(enc_idx) * RGB_W +: RGB_W];
        sel_valid = 1'b1;
        sel_idx   = enc_idx;
      end else begin
        sel_rgb = active_bg;
      end
    end
  end

  // Single output register stage: pixel decided in cycle N appears in cycle N+1.
  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) begin
      Red_level    <= '0;
      Green_level  <= '0;
      Blue_level   <= '0;
      winner_valid <= 1'b0;
      winner_idx   <= '0;
    end else begin
      Red_level    <= sel_rgb[3*COLOR_W-1:2*COLOR_W];
      Green_level  <= sel_rgb[2*COLOR_W-1:COLOR_W];
      Blue_level   <= sel_rgb[COLOR_W-1:0];
      winner_valid <= sel_valid;
      winner_idx   <= sel_idx;
    end
  end

`ifdef COLLISION_DETECT_EN
  logic [NUM_LAYERS-1:0] coll_acc;
  logic [NUM_LAYERS-1:0] coll_next;
  logic                  multi_req;

  assign multi_req = (eff & (eff - NUM_LAYERS'(1))) != '0;

  // Fold this pixel's overlap into the accumulator so a frame-cycle collision reaches the snapshot.
  always_comb begin
    coll_next = coll_acc;
    if (disp_ena && multi_req) begin
      coll_next = coll_acc | eff;
    end
  end

  // Snapshot and clear on each frame pulse; pulse flags a nonzero snapshot.
  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) begin
      coll_acc        <= '0;
      collision_mask  <= '0;
      collision_pulse <= 1'b0;
    end else if (frame) begin
      coll_acc        <= '0;
      collision_mask  <= coll_next;
      collision_pulse <= |coll_next;
    end else begin
      coll_acc        <= coll_next;
      collision_pulse <= 1'b0;
    end
  end
`else
  // No collision tracking in this build.
`endif

endmodule

// File: tb/tb_display_layer_arbiter.sv
// tb/tb_display_layer_arbiter.sv - scoreboard bench for display_layer_arbiter
module tb_display_layer_arbiter;

  logic        clk_25 = 1'b0;
  logic        reset;
  logic        frame;
  logic        disp_ena;
  logic [3:0]  draw_req;
  logic [47:0] layer_rgb;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [3:0]  cfg_enable_mask;
  logic [11:0] cfg_bg_rgb;
  logic [3:0]  Red_level;
  logic [3:0]  Green_level;
  logic [3:0]  Blue_level;
  logic        winner_valid;
  logic [1:0]  winner_idx;
  logic        pending_cfg;
  logic [3:0]  collision_mask;
  logic        collision_pulse;

  always #20 clk_25 = ~clk_25;

  display_layer_arbiter dut (
    .clk_25          (clk_25),
    .reset           (reset),
    .frame           (frame),
    .disp_ena        (disp_ena),
    .draw_req        (draw_req),
    .layer_rgb       (layer_rgb),
    .cfg_valid       (cfg_valid),
    .cfg_ready       (cfg_ready),
    .cfg_enable_mask (cfg_enable_mask),
    .cfg_bg_rgb      (cfg_bg_rgb),
    .Red_level       (Red_level),
    .Green_level     (Green_level),
    .Blue_level      (Blue_level),
    .winner_valid    (winner_valid),
    .winner_idx      (winner_idx),
`ifdef COLLISION_DETECT_EN
    .collision_mask  (collision_mask),
    .collision_pulse (collision_pulse),
`endif
    .pending_cfg     (pending_cfg)
  );

`ifndef COLLISION_DETECT_EN
  assign collision_mask  = 4'b0;
  assign collision_pulse = 1'b0;
`endif

  typedef struct {
    int         step;
    logic [11:0] rgb;
    logic        v;
    logic [1:0]  idx;
    logic        rdy;
    logic        pend;
    logic [3:0]  cm;
    logic        cp;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   step_no  = 0;

  task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
    end
  endtask

  // Monitor: every registered output sample is matched against the oldest expectation.
  always @(posedge clk_25) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rgb", e.step, {20'd0, Red_level, Green_level, Blue_level}, {20'd0, e.rgb});
      chk("winner_valid", e.step, {31'd0, winner_valid}, {31'd0, e.v});
      chk("winner_idx", e.step, {30'd0, winner_idx}, {30'd0, e.idx});
      chk("cfg_ready", e.step, {31'd0, cfg_ready}, {31'd0, e.rdy});
      chk("pending_cfg", e.step, {31'd0, pending_cfg}, {31'd0, e.pend});
`ifdef COLLISION_DETECT_EN
      chk("collision_mask", e.step, {28'd0, collision_mask}, {28'd0, e.cm});
      chk("collision_pulse", e.step, {31'd0, collision_pulse}, {31'd0, e.cp});
`endif
    end
  end

  task automatic step(input logic rst, input logic de, input logic [3:0] req, input logic frm,
                      input logic cv, input logic [3:0] cmask, input logic [11:0] cbg,
                      input logic [11:0] e_rgb, input logic e_v, input logic [1:0] e_i,
                      input logic e_rdy, input logic e_pend, input logic [3:0] e_cm, input logic e_cp);
    exp_t e;
    @(negedge clk_25);
    reset           = rst;
    disp_ena        = de;
    draw_req        = req;
    frame           = frm;
    cfg_valid       = cv;
    cfg_enable_mask = cmask;
    cfg_bg_rgb      = cbg;
    e.step = step_no;
    e.rgb  = e_rgb;
    e.v    = e_v;
    e.idx  = e_i;
    e.rdy  = e_rdy;
    e.pend = e_pend;
    e.cm   = e_cm;
    e.cp   = e_cp;
    sb.push_back(e);
    step_no++;
  endtask

  initial begin
    reset           = 1'b1;
    frame           = 1'b0;
    disp_ena        = 1'b0;
    draw_req        = 4'b0;
    cfg_valid       = 1'b0;
    cfg_enable_mask = 4'b0;
    cfg_bg_rgb      = 12'h000;
    layer_rgb       = {12'h456, 12'h0F0, 12'hF00, 12'h123};

    //   rst de  req    frm cv  mask   bg       rgb      v  idx  rdy pend cm     cp
    step(1, 0, 4'b0000, 0, 0, 4'b0000, 12'h000, 12'h000, 0, 2'd0, 1, 0, 4'b0000, 0); // s0 reset
    step(0, 1, 4'b0110, 0, 0, 4'b0000, 12'h000, 12'hF00, 1, 2'd1, 1, 0, 4'b0000, 0); // s1 priority
    step(0, 1, 4'b0001, 0, 0, 4'b0000, 12'h000, 12'h123, 1, 2'd0, 1, 0, 4'b0000, 0); // s2
    step(0, 1, 4'b1000, 0, 0, 4'b0000, 12'h000, 12'h456, 1, 2'd3, 1, 0, 4'b0000, 0); // s3
    step(0, 1, 4'b0000, 0, 0, 4'b0000, 12'h000, 12'h000, 0, 2'd0, 1, 0, 4'b0000, 0); // s4 bg=0
    step(0, 1, 4'b0110, 0, 1, 4'b1101, 12'h000, 12'hF00, 1, 2'd1, 0, 1, 4'b0000, 0); // s5 write mask
    step(0, 1, 4'b0110, 0, 1, 4'b0000, 12'h000, 12'hF00, 1, 2'd1, 0, 1, 4'b0000, 0); // s6 write refused
    step(0, 1, 4'b0110, 1, 0, 4'b0000, 12'h000, 12'hF00, 1, 2'd1, 1, 0, 4'b0110, 1); // s7 frame: old cfg
    step(0, 1, 4'b0110, 0, 0, 4'b0000, 12'h000, 12'h0F0, 1, 2'd2, 1, 0, 4'b0110, 0); // s8 layer2 wins
    step(0, 1, 4'b0010, 0, 0, 4'b0000, 12'h000, 12'h000, 0, 2'd0, 1, 0, 4'b0110, 0); // s9 masked -> bg
    step(0, 1, 4'b0000, 0, 1, 4'b1101, 12'h00F, 12'h000, 0, 2'd0, 0, 1, 4'b0110, 0); // s10 write bg
    step(0, 1, 4'b0000, 1, 0, 4'b0000, 12'h000, 12'h000, 0, 2'd0, 1, 0, 4'b0000, 0); // s11 frame
    step(0, 1, 4'b0000, 0, 0, 4'b0000, 12'h000, 12'h00F, 0, 2'd0, 1, 0, 4'b0000, 0); // s12 new bg
    step(0, 0, 4'b1111, 0, 0, 4'b0000, 12'h000, 12'h000, 0, 2'd0, 1, 0, 4'b0000, 0); // s13 blanking
    step(0, 1, 4'b1111, 0, 1, 4'b0000, 12'h00F, 12'h123, 1, 2'd0, 0, 1, 4'b0000, 0); // s14 write mask 0
    step(0, 1, 4'b1111, 1, 0, 4'b0000, 12'h000, 12'h123, 1, 2'd0, 1, 0, 4'b1101, 1); // s15 frame
    step(0, 1, 4'b1111, 0, 0, 4'b0000, 12'h000, 12'h00F, 0, 2'd0, 1, 0, 4'b1101, 0); // s16 mask 0 -> bg
    step(0, 1, 4'b0100, 1, 1, 4'b1111, 12'h0AB, 12'h00F, 0, 2'd0, 0, 1, 4'b0000, 0); // s17 cv+frame idle
    step(0, 1, 4'b0100, 0, 0, 4'b0000, 12'h000, 12'h00F, 0, 2'd0, 0, 1, 4'b0000, 0); // s18 still pending
    step(0, 1, 4'b0100, 1, 0, 4'b0000, 12'h000, 12'h00F, 0, 2'd0, 1, 0, 4'b0000, 0); // s19 commit frame
    step(0, 1, 4'b0100, 0, 0, 4'b0000, 12'h000, 12'h0F0, 1, 2'd2, 1, 0, 4'b0000, 0); // s20 applied
    step(0, 1, 4'b0100, 0, 1, 4'b0000, 12'h0CC, 12'h0F0, 1, 2'd2, 0, 1, 4'b0000, 0); // s21 write
    step(1, 1, 4'b0100, 0, 0, 4'b0000, 12'h000, 12'h000, 0, 2'd0, 1, 0, 4'b0000, 0); // s22 reset mid-pending
    step(0, 1, 4'b0000, 0, 0, 4'b0000, 12'h000, 12'h000, 0, 2'd0, 1, 0, 4'b0000, 0); // s23 bg back to 0
    step(0, 1, 4'b1000, 0, 0, 4'b0000, 12'h000, 12'h456, 1, 2'd3, 1, 0, 4'b0000, 0); // s24 mask all ones
    step(0, 1, 4'b1001, 0, 0, 4'b0000, 12'h000, 12'h123, 1, 2'd0, 1, 0, 4'b0000, 0); // s25 overlap 0,3
    step(0, 1, 4'b0000, 0, 0, 4'b0000, 12'h000, 12'h000, 0, 2'd0, 1, 0, 4'b0000, 0); // s26
    step(0, 1, 4'b0000, 1, 0, 4'b0000, 12'h000, 12'h000, 0, 2'd0, 1, 0, 4'b1001, 1); // s27 snapshot
    step(0, 1, 4'b0000, 0, 0, 4'b0000, 12'h000, 12'h000, 0, 2'd0, 1, 0, 4'b1001, 0); // s28 pulse drops
    step(0, 1, 4'b0000, 1, 0, 4'b0000, 12'h000, 12'h000, 0, 2'd0, 1, 0, 4'b0000, 0); // s29 clean frame
    step(0, 1, 4'b0011, 1, 0, 4'b0000, 12'h000, 12'h123, 1, 2'd0, 1, 0, 4'b0011, 1); // s30 frame-cycle overlap
    step(0, 1, 4'b0000, 0, 0, 4'b0000, 12'h000, 12'h000, 0, 2'd0, 1, 0, 4'b0011, 0); // s31

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk_25);
    #2;
    n_assert++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
